// File: rtl/wasm_pkg.sv
// Shared definitions for the wasm cpu front end: trap encoding, LEB128 decoder
// FSM states and maximum encoded immediate lengths.
package wasm_pkg;

    localparam logic [2:0] TRAP_NONE         = 3'd0;
    localparam logic [2:0] TRAP_LEB_OVERFLOW = 3'd1;
    localparam logic [2:0] TRAP_LEB_TOO_LONG = 3'd2;

    localparam int unsigned MAX_BYTES_32 = 5;
    localparam int unsigned MAX_BYTES_64 = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE,
        ST_ERROR
    } leb_state_e;

endpackage

// File: rtl/leb128_last_byte_check.sv
// Legality of the byte that reaches the maximum encoded length: it must
// terminate and must not carry payload bits beyond the target width.
module leb128_last_byte_check (
    input  logic [7:0] data_i,
    input  logic       is_signed_i,
    input  logic       is_64_i,
    output logic       too_long_o,
    output logic       overflow_o
);

    always_comb begin
        too_long_o = data_i[7];
        unique case ({is_64_i, is_signed_i})
            2'b00:   overflow_o = |data_i[6:4];
            2'b01:   overflow_o = !((data_i[6:3] == 4'h0) || (data_i[6:3] == 4'hF));
            2'b10:   overflow_o = |data_i[6:1];
            default: overflow_o = !((data_i[6:0] == 7'h00) || (data_i[6:0] == 7'h7F));
        endcase
    end

endmodule

// File: rtl/leb128_decoder.sv
// Assembles one signed/unsigned 32/64-bit LEB128 immediate from the fetch byte
// stream and delivers it as a stack-ready 64-bit value, or raises a trap.
module leb128_decoder
    import wasm_pkg::*;
#(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MAX_BYTES_32 = wasm_pkg::MAX_BYTES_32,
    parameter int unsigned MAX_BYTES_64 = wasm_pkg::MAX_BYTES_64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_signed,
    input  logic              is_64,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_value,
    output logic [3:0]        out_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [2:0]        trap
);

    leb_state_e        state_q, state_d;
    logic              signed_q, signed_d;
    logic              w64_q, w64_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [6:0]        shift_q, shift_d;
    logic [3:0]        count_q, count_d;
    logic [DATA_W-1:0] out_value_q, out_value_d;
    logic [3:0]        out_len_q, out_len_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        trap_q, trap_d;

    logic [6:0]        shift_new;
    logic [3:0]        count_new;
    logic [DATA_W-1:0] acc_new, acc_fin, result;
    logic              at_max, too_long, overflow;

    leb128_last_byte_check u_check (
        .data_i      (in_data),
        .is_signed_i (signed_q),
        .is_64_i     (w64_q),
        .too_long_o  (too_long),
        .overflow_o  (overflow)
    );

    assign in_ready  = (state_q == ST_ACCUM);
    assign busy      = (state_q != ST_IDLE);
    assign out_value = out_value_q;
    assign out_len   = out_len_q;
    assign out_valid = out_valid_q;
    assign trap      = trap_q;

    // Payload bits landing above bit 63 fall off the shift; the last-byte check covers them.
    always_comb begin
        shift_new = shift_q + 7'd7;
        count_new = count_q + 4'd1;
        acc_new   = acc_q | (DATA_W'(in_data[6:0]) << shift_q[5:0]);
        acc_fin   = acc_new;
        if (signed_q && (shift_new < (w64_q ? 7'd64 : 7'd32)) && in_data[6])
            acc_fin = acc_new | ({DATA_W{1'b1}} << shift_new[5:0]);
        if (w64_q)
            result = acc_fin;
        else if (signed_q)
            result = {{(DATA_W-32){acc_fin[31]}}, acc_fin[31:0]};
        else
            result = {{(DATA_W-32){1'b0}}, acc_fin[31:0]};
        at_max = (count_new == (w64_q ? 4'(MAX_BYTES_64) : 4'(MAX_BYTES_32)));
    end

    always_comb begin
        state_d     = state_q;
        signed_d    = signed_q;
        w64_d       = w64_q;
        acc_d       = acc_q;
        shift_d     = shift_q;
        count_d     = count_q;
        out_value_d = out_value_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q;
        trap_d      = trap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    signed_d = is_signed;
                    w64_d    = is_64;
                    acc_d    = '0;
                    shift_d  = '0;
                    count_d  = '0;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d   = acc_new;
                    shift_d = shift_new;
                    count_d = count_new;
                    if (at_max && (too_long || overflow)) begin
                        trap_d  = too_long ? TRAP_LEB_TOO_LONG : TRAP_LEB_OVERFLOW;
                        state_d = ST_ERROR;
                    end else if (!in_data[7]) begin
                        out_value_d = result;
                        out_len_d   = count_new;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            signed_q    <= 1'b0;
            w64_q       <= 1'b0;
            acc_q       <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            out_value_q <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            trap_q      <= TRAP_NONE;
        end else begin
            state_q     <= state_d;
            signed_q    <= signed_d;
            w64_q       <= w64_d;
            acc_q       <= acc_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            out_value_q <= out_value_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
            trap_q      <= trap_d;
        end
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Self-checking bench for leb128_decoder: directed vector table, hand-written
// corner sequences and random decodes against an arithmetic reference model.
module tb_leb128_decoder;
    import wasm_pkg::*;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        bit          sgn;
        bit          w64;
        int          n;
        logic [79:0] bytes;
        logic [63:0] val;
        int          len;
        logic [2:0]  trp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, is_signed, is_64, in_valid, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, busy;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic [2:0]  trap;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    leb128_decoder #(.DATA_W(64), .MAX_BYTES_32(5), .MAX_BYTES_64(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .is_64     (is_64),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .trap      (trap)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: build the whole encoded integer at 128 bits, then range-check it.
    task automatic ref_model(input bit sgn, input bit w64, input bq_t b,
                             output logic [63:0] val, output int len, output logic [2:0] trp);
        logic [127:0] full;
        logic [127:0] hi;
        int           maxb, w, n;
        maxb = w64 ? 10 : 5;
        w    = w64 ? 64 : 32;
        full = '0;
        n    = 0;
        trp  = TRAP_NONE;
        foreach (b[i]) begin
            n++;
            full = full | (128'(b[i][6:0]) << (7 * (n - 1)));
            if (!b[i][7] || n == maxb) break;
        end
        len = n;
        if (n == maxb && b[n-1][7]) trp = TRAP_LEB_TOO_LONG;
        if (sgn && full[7*n-1]) full = full | ({128{1'b1}} << (7 * n));
        if (n == maxb && trp == TRAP_NONE) begin
            if (sgn) begin
                hi = full >> (w - 1);
                if (!(hi == '0 || hi == ({128{1'b1}} >> (w - 1)))) trp = TRAP_LEB_OVERFLOW;
            end else begin
                if ((full >> w) != '0) trp = TRAP_LEB_OVERFLOW;
            end
        end
        if (w64)      val = full[63:0];
        else if (sgn) val = {{32{full[31]}}, full[31:0]};
        else          val = {32'h0, full[31:0]};
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, " rst busy"}, 64'(busy), 64'd0);
        chk({tag, " rst in_ready"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk({tag, " rst trap"}, 64'(trap), 64'(TRAP_NONE));
        chk({tag, " rst out_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_decode(input string tag, input bit sgn, input bit w64, input bq_t b,
                              input logic [63:0] e_val, input int e_len, input logic [2:0] e_trap,
                              input int gap, input bit rnd_gap, input int hold);
        int g;
        start     = 1'b1;
        is_signed = sgn;
        is_64     = w64;
        in_valid  = 1'b1;
        in_data   = 8'h81;
        tick();
        start     = 1'b0;
        in_valid  = 1'b0;
        is_signed = ~sgn;
        is_64     = ~w64;
        chk({tag, " busy"}, 64'(busy), 64'd1);
        foreach (b[i]) begin
            g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
            repeat (g) tick();
            chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = b[i];
            tick();
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        chk({tag, " trap"}, 64'(trap), 64'(e_trap));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(e_trap == TRAP_NONE));
        chk({tag, " in_ready after"}, 64'(in_ready), 64'd0);
        if (e_trap != TRAP_NONE) begin
            repeat (3) tick();
            chk({tag, " trap held"}, 64'(trap), 64'(e_trap));
            chk({tag, " err out_valid"}, 64'(out_valid), 64'd0);
            chk({tag, " err in_ready"}, 64'(in_ready), 64'd0);
        end else begin
            chk({tag, " value"}, out_value, e_val);
            chk({tag, " len"}, 64'(out_len), 64'(e_len));
            for (int k = 0; k < hold; k++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                tick();
                chk({tag, " hold value"}, out_value, e_val);
                chk({tag, " hold len"}, 64'(out_len), 64'(e_len));
                chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
                chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            start     = 1'b1;
            tick();
            out_ready = 1'b0;
            start     = 1'b0;
            chk({tag, " ack out_valid"}, 64'(out_valid), 64'd0);
            chk({tag, " ack bubble"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic add_vec(input bit sgn, input bit w64, input bq_t b,
                           input logic [63:0] val, input int len, input logic [2:0] trp);
        vec_t v;
        v.sgn   = sgn;
        v.w64   = w64;
        v.n     = b.size();
        v.bytes = '0;
        foreach (b[i]) v.bytes[8*i +: 8] = b[i];
        v.val   = val;
        v.len   = len;
        v.trp   = trp;
        tbl.push_back(v);
    endtask

    task automatic gen_bytes(input bit w64, output bq_t b);
        int   maxb, n;
        logic [7:0] last;
        maxb = w64 ? 10 : 5;
        n    = int'($urandom_range(maxb, 1));
        b    = {};
        for (int i = 0; i < n - 1; i++) b.push_back(8'h80 | 8'($urandom));
        last = {1'b0, 7'($urandom)};
        if (n == maxb) begin
            case ($urandom_range(5, 0))
                0: last = 8'h00;
                1: last = 8'h7F;
                2: last = 8'h01;
                3: last = {5'b0, 3'($urandom)};
                4: last = 8'h80 | 8'($urandom);
                default: ;
            endcase
        end
        b.push_back(last);
    endtask

    initial begin
        bq_t         q;
        logic [63:0] m_val;
        int          m_len;
        logic [2:0]  m_trp;
        bit          sgn, w64;

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; is_64 = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) tick();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset trap", 64'(trap), 64'(TRAP_NONE));
        chk("reset out_value", out_value, 64'd0);
        chk("reset out_len", 64'(out_len), 64'd0);
        reset = 1'b0;
        tick();

        add_vec(0, 0, '{8'hE5, 8'h8E, 8'h26}, 64'h0000_0000_0009_8765, 3, TRAP_NONE);
        add_vec(1, 0, '{8'h7F}, 64'hFFFF_FFFF_FFFF_FFFF, 1, TRAP_NONE);
        add_vec(1, 1, '{8'hC0, 8'hBB, 8'h78}, 64'hFFFF_FFFF_FFFE_1DC0, 3, TRAP_NONE);
        add_vec(0, 0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F}, 64'h0000_0000_FFFF_FFFF, 5, TRAP_NONE);
        add_vec(0, 0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F}, 64'h0, 0, TRAP_LEB_OVERFLOW);
        add_vec(0, 1, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80},
                64'h0, 0, TRAP_LEB_TOO_LONG);
        add_vec(1, 1, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F},
                64'h8000_0000_0000_0000, 10, TRAP_NONE);
        add_vec(0, 1, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01},
                64'hFFFF_FFFF_FFFF_FFFF, 10, TRAP_NONE);
        add_vec(1, 0, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h78}, 64'hFFFF_FFFF_8000_0000, 5, TRAP_NONE);
        add_vec(1, 0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F}, 64'h0, 0, TRAP_LEB_OVERFLOW);
        add_vec(0, 0, '{8'h2A}, 64'h2A, 1, TRAP_NONE);

        foreach (tbl[k]) begin
            q = {};
            for (int i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].bytes[8*i +: 8]);
            run_decode($sformatf("vec%0d", k), tbl[k].sgn, tbl[k].w64, q,
                       tbl[k].val, tbl[k].len, tbl[k].trp, 0, 1'b0, 0);
            if (tbl[k].trp != TRAP_NONE) do_reset($sformatf("vec%0d", k));
        end

        run_decode("backpressure", 0, 0, '{8'hE5, 8'h8E, 8'h26}, 64'h98765, 3, TRAP_NONE,
                   2, 1'b0, 3);

        // Abort mid-decode after two bytes, then a fresh decode must show no residue.
        start = 1'b1; is_signed = 1'b0; is_64 = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'hE5; tick();
        in_data = 8'h8E; tick();
        in_valid = 1'b0;
        do_reset("abort");
        run_decode("after abort", 0, 0, '{8'h2A}, 64'h2A, 1, TRAP_NONE, 0, 1'b0, 0);

        for (int r = 0; r < 150; r++) begin
            sgn = 1'($urandom);
            w64 = 1'($urandom);
            gen_bytes(w64, q);
            ref_model(sgn, w64, q, m_val, m_len, m_trp);
            run_decode($sformatf("rnd%0d", r), sgn, w64, q, m_val, m_len, m_trp,
                       2, 1'b1, int'($urandom_range(2, 0)));
            if (m_trp != TRAP_NONE) do_reset($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
Front-end immediate decoder for the wasm cpu core. It consumes the instruction byte stream from the ROM fetch path and assembles one LEB128-encoded immediate per request. Immediates are signed or unsigned, 32- or 64-bit. Each result is delivered as a 64-bit stack-ready value, together with the byte count, to the decode/execute stage. Malformed encodings raise a trap code that the cpu forwards on its trap output.

Parameters:
DATA_W, 64, width of out_value (cpu stack word)
MAX_BYTES_32, 5, maximum encoded length for 32-bit immediates
MAX_BYTES_64, 10, maximum encoded length for 64-bit immediates

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a decode; sampled only in IDLE
is_signed  input  1  sLEB when 1, uLEB when 0; latched on start
is_64  input  1  64-bit immediate when 1, 32-bit when 0; latched on start
in_data  input  8  byte from ROM fetch
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted when in_valid && in_ready
out_value  output  64  decoded immediate
out_len  output  4  bytes consumed (1..10)
out_valid  output  1  result valid; held until out_ready
out_ready  input  1  consumer accepts result
busy  output  1  state != IDLE
trap  output  3  0 = none, else a trap code from the shared package

Behaviour:
- FSM states are IDLE, ACCUM, DONE, ERROR. Reset forces IDLE, acc=0, shift=0, count=0, out_value=0, out_len=0, out_valid=0, in_ready=0, trap=0, busy=0.
- IDLE: in_ready=0. When start=1, latch is_signed and is_64, clear acc, shift and count, then go to ACCUM. A byte presented in the same cycle as start is not consumed.
- ACCUM: in_ready=1. On each accepted byte:
  - acc |= byte[6:0] << shift; shift += 7; count += 1.
  - If byte[7]=0, finish: for signed modes with shift_new < W and byte[6]=1, sign-extend acc above bit shift_new-1.
  - A 32-bit result is then zero-extended (u32) or sign-extended from bit 31 (s32) to 64 bits.
  - out_value, out_len=count_new and out_valid=1 register, then go to DONE. out_valid is asserted the cycle after the last byte handshake.
  - in_valid=0 simply stalls; state is held.
- Final-byte legality, checked when count_new == MAX (5 or 10):
  - byte[7]=1 -> TRAP_LEB_TOO_LONG.
  - u32: byte[6:4] != 0 -> TRAP_LEB_OVERFLOW.
  - s32: byte[6:3] not all equal -> TRAP_LEB_OVERFLOW.
  - u64: byte[6:1] != 0 -> TRAP_LEB_OVERFLOW.
  - s64: byte[6:0] not 0x00 or 0x7F -> TRAP_LEB_OVERFLOW.
  - Any violation goes to ERROR instead of DONE; out_valid stays 0.
- DONE: in_ready=0. out_value and out_len stay stable while out_valid=1 && out_ready=0. On out_ready=1, clear out_valid and return to IDLE. A start in the same cycle is ignored, so there is one bubble cycle minimum between decodes.
- ERROR: in_ready=0, out_valid=0. trap holds its code until reset, and only reset exits ERROR. The cpu halts on a nonzero trap.
- start outside IDLE is ignored. is_signed and is_64 are ignored after latching.
- An asynchronous reset mid-decode discards all partial state: next cycle in_ready=0 and busy=0.
- Width rules: the shift amount never exceeds 63, because the count limit guarantees it. Bits shifted above bit 63 are dropped; the legality check covers them.

Decomposition:
- Package wasm_pkg holds:
  - trap codes TRAP_NONE=3'd0, TRAP_LEB_OVERFLOW, TRAP_LEB_TOO_LONG (values shared with the cpu trap encoding);
  - the FSM state enum;
  - MAX_BYTES constants.
- One combinational sub-module, leb128_last_byte_check: inputs byte, is_signed, is_64; outputs too_long and overflow. Everything else lives in leb128_decoder.

Test Plan:
- u32, bytes E5 8E 26 -> out_value=0x0000000000098765 (624485), out_len=3, out_valid one cycle after third byte.
- s32, byte 7F -> out_value=0xFFFFFFFFFFFFFFFF, out_len=1. Then s64 C0 BB 78 -> 0xFFFFFFFFFFFE1DC0 (-123456), out_len=3.
- u32, FF FF FF FF 0F -> 0x00000000FFFFFFFF, len 5. After reset, u32 FF FF FF FF 1F -> trap=TRAP_LEB_OVERFLOW, out_valid=0, in_ready=0, held until reset.
- u64, ten bytes of 80 -> trap=TRAP_LEB_TOO_LONG on the 10th byte. s64, nine 80 followed by 7F -> out_value=0x8000000000000000, len 10.
- Backpressure: u32 E5 8E 26 with in_valid gaps of 2 cycles and out_ready low for 3 cycles -> same value; out_value and out_len stable throughout; no byte accepted in DONE.
- Reset asserted asynchronously after 2 of 3 bytes -> busy=0, in_ready=0 immediately. Fresh u32 decode of 2A -> 0x2A, len 1, no residue from the aborted decode.
